// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: pipeline requester A has priority, the
// long-latency requester B is force-granted after waiting STARVE_LIMIT cycles.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_stall,
  output logic [3:0]  o_starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  r_cnt;
  logic        r_wren;
  logic [4:0]  r_addr;
  logic [31:0] r_data;

  logic        w_force;
  logic        w_conflict;
  logic [3:0]  w_cnt_nxt;
  logic        w_wren_nxt;
  logic [4:0]  w_addr_nxt;
  logic [31:0] w_data_nxt;

  // Grant decision: forced B grant beats A; same-address B is swallowed when A wins.
  always_comb begin
    w_force    = i_b_valid & (r_cnt == LIMIT);
    w_conflict = i_a_valid & i_b_valid & (i_a_addr == i_b_addr) & (i_a_addr != 5'd0);
    o_a_ready  = 1'b0;
    o_b_ready  = 1'b0;
    if (i_rst) begin
      o_a_ready = 1'b0;
      o_b_ready = 1'b0;
    end else if (w_force) begin
      o_b_ready = 1'b1;
    end else if (i_a_valid) begin
      o_a_ready = 1'b1;
      o_b_ready = w_conflict;
    end else begin
      o_b_ready = i_b_valid;
    end
  end

  // Next-state for the wait counter and the registered write port.
  always_comb begin
    w_cnt_nxt  = 4'd0;
    w_wren_nxt = 1'b0;
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    if (i_b_valid & ~o_b_ready) begin
      if (r_cnt >= LIMIT) begin
        w_cnt_nxt = LIMIT;
      end else begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end else begin
      w_cnt_nxt = 4'd0;
    end
    if (o_a_ready) begin
      w_wren_nxt = (i_a_addr != 5'd0);
      w_addr_nxt = i_a_addr;
      w_data_nxt = i_a_data;
    end else if (o_b_ready) begin
      w_wren_nxt = (i_b_addr != 5'd0);
      w_addr_nxt = i_b_addr;
      w_data_nxt = i_b_data;
    end else begin
      w_wren_nxt = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 4'd0;
      r_wren <= 1'b0;
      r_addr <= 5'd0;
      r_data <= 32'd0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wren <= w_wren_nxt;
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
    end
  end

  // Outputs read as zero for the whole reset window, including its first cycle.
  always_comb begin
    o_rd_wren    = r_wren & ~i_rst;
    o_rd_addr    = i_rst ? 5'd0 : r_addr;
    o_rd_data    = i_rst ? 32'd0 : r_data;
    o_starve_cnt = i_rst ? 4'd0 : r_cnt;
    o_stall      = i_a_valid & ~o_a_ready;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter (STARVE_LIMIT = 4).
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rd_wren, stall;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  starve_cnt;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_rd_wren(rd_wren), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_stall(stall), .o_starve_cnt(starve_cnt)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_st;
    logic [3:0]  e_cnt;
    logic        e_wr;
    logic        chk_ad;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic ear, logic ebr, logic est, logic [3:0] ecnt,
                              logic ewr, logic chk, logic [4:0] eaddr, logic [31:0] edata);
    vec_t v;
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.e_ar = ear; v.e_br = ebr; v.e_st = est; v.e_cnt = ecnt;
    v.e_wr = ewr; v.chk_ad = chk; v.e_addr = eaddr; v.e_data = edata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, n_vec, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic apply(input vec_t v);
    drive(v.rst, v.av, v.aa, v.ad, v.bv, v.ba, v.bd);
    n_vec++;
    #2;
    check("a_ready", {31'd0, a_ready}, {31'd0, v.e_ar});
    check("b_ready", {31'd0, b_ready}, {31'd0, v.e_br});
    check("stall", {31'd0, stall}, {31'd0, v.e_st});
    check("starve_cnt", {28'd0, starve_cnt}, {28'd0, v.e_cnt});
    @(posedge clk);
    #1;
    check("rd_wren", {31'd0, rd_wren}, {31'd0, v.e_wr});
    if (v.chk_ad) begin
      check("rd_addr", {27'd0, rd_addr}, {27'd0, v.e_addr});
      check("rd_data", rd_data, v.e_data);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset state with A requesting: stall follows A valid
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 32'h1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5'd0, 32'd0));
    // A only
    tbl.push_back(mk(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF));
    // starvation of B (addr 7) by A (addr 1)
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b0, 1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'd7, 32'h11,  1'b1, 1'b0, 1'b0, 4'(k), 1'b1, 1'b1, 5'd1, 32'h100 + 32'(k)));
    tbl.push_back(mk(1'b0, 1'b1, 5'd1, 32'h104, 1'b1, 5'd7, 32'h11,  1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 5'd7, 32'h11));
    tbl.push_back(mk(1'b0, 1'b1, 5'd1, 32'h104, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd1, 32'h104));
    // same-address conflict: only A's value lands
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd3, 32'hA));
    // idle: no B write follows, port holds
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'hA));
    // x0 write by B alone
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'd0));
    // build counter to 3, then reset with both valid
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 1'b1, 5'd2, 32'h200 + 32'(k), 1'b1, 5'd9, 32'h99,  1'b1, 1'b0, 1'b0, 4'(k), 1'b1, 1'b1, 5'd2, 32'h200 + 32'(k)));
    tbl.push_back(mk(1'b1, 1'b1, 5'd2, 32'h203, 1'b1, 5'd9, 32'h99,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 5'd0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd2, 32'h203, 1'b1, 5'd9, 32'h99,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd2, 32'h203));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99,  1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 5'd9, 32'h99));
    // only B valid from idle counter
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h55,  1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd10, 32'h55));

    foreach (tbl[i]) apply(tbl[i]);

    // Same-address conflict under forced grant: B lands first, A next cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 5'd1, 32'h300 + 32'(k), 1'b1, 5'd6, 32'hB6);
      n_vec++;
      #2;
      check("fc_cnt", {28'd0, starve_cnt}, 32'(k));
      check("fc_a_ready", {31'd0, a_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b1, 5'd6, 32'hA6, 1'b1, 5'd6, 32'hB6);
    n_vec++;
    #2;
    check("fc_force_b_ready", {31'd0, b_ready}, 32'd1);
    check("fc_force_a_ready", {31'd0, a_ready}, 32'd0);
    check("fc_force_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    check("fc_b_wren", {31'd0, rd_wren}, 32'd1);
    check("fc_b_addr", {27'd0, rd_addr}, 32'd6);
    check("fc_b_data", rd_data, 32'hB6);
    drive(1'b0, 1'b1, 5'd6, 32'hA6, 1'b0, 5'd0, 32'd0);
    n_vec++;
    #2;
    check("fc_after_cnt", {28'd0, starve_cnt}, 32'd0);
    check("fc_after_a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("fc_a_wren", {31'd0, rd_wren}, 32'd1);
    check("fc_a_addr", {27'd0, rd_addr}, 32'd6);
    check("fc_a_data", rd_data, 32'hA6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL be the number of consecutive cycles B may wait before forced grant (legal range 1..15).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 i_a_valid  input  1  SHALL indicate a pipeline writeback request (requester A).
REQ-005 i_a_addr  input  5  SHALL be A's destination register index.
REQ-006 i_a_data  input  32  SHALL be A's write data.
REQ-007 o_a_ready  output  1  SHALL indicate A's request is accepted this cycle.
REQ-008 i_b_valid  input  1  SHALL indicate a long-latency unit writeback request (requester B).
REQ-009 i_b_addr  input  5  SHALL be B's destination register index.
REQ-010 i_b_data  input  32  SHALL be B's write data.
REQ-011 o_b_ready  output  1  SHALL indicate B's request is consumed this cycle.
REQ-012 o_rd_wren  output  1  SHALL be the register-file write enable.
REQ-013 o_rd_addr  output  5  SHALL be the register-file write index.
REQ-014 o_rd_data  output  32  SHALL be the register-file write data.
REQ-015 o_stall  output  1  SHALL equal i_a_valid & ~o_a_ready (pipeline hold).
REQ-016 o_starve_cnt  output  4  SHALL expose the current B wait counter.

Function
REQ-017 Handshake: a request transfers when valid & ready in the same cycle; requesters hold addr/data stable while valid & ~ready.
REQ-018 o_a_ready/o_b_ready SHALL be combinational from valids, addresses and the wait counter; at most one of them grants a write per cycle.
REQ-019 Default priority: A wins whenever i_a_valid=1 and the counter is below STARVE_LIMIT.
REQ-020 Forced grant: when i_b_valid=1 and counter == STARVE_LIMIT, B SHALL be granted and A SHALL see o_a_ready=0 (o_stall=1).
REQ-021 Counter: increments (saturating at STARVE_LIMIT) each cycle i_b_valid=1 and B not consumed; clears to 0 on B consumed or i_b_valid=0.
REQ-022 Only B valid: B SHALL be granted the same cycle, counter stays 0.
REQ-023 Same-address conflict: A and B both valid, equal nonzero addresses, A granted -> o_b_ready=1 too; B consumed and discarded (A is younger, B must not overwrite).
REQ-024 Same-address conflict under forced grant: B written first; A stalled, written next cycle (correct order).
REQ-025 Write port registered: granted request SHALL appear on o_rd_wren/addr/data exactly one cycle after the handshake cycle.
REQ-026 x0 writes: a granted request with addr 0 SHALL be consumed with o_rd_wren=0 next cycle.
REQ-027 No grant in a cycle -> o_rd_wren=0 next cycle; o_rd_addr/o_rd_data hold previous values.
REQ-028 Register file consumes o_rd_* on its own edge; this block makes no assumption beyond one-cycle stable outputs.

Reset
REQ-029 While i_rst=1: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, counter=0, o_a_ready=0, o_b_ready=0, o_stall=i_a_valid.
REQ-030 Reset asserted mid-transfer SHALL drop any request handshaken in that cycle; no write issued in the cycle after reset.
REQ-031 First grant possible in the first cycle with i_rst=0.

Verification
REQ-032 A only: A valid addr=5 data=0xDEADBEEF -> o_a_ready=1; next cycle wren=1, addr=5, data=0xDEADBEEF.
REQ-033 Starvation: A valid every cycle, B valid addr=7 data=0x11 -> counter 1,2,3,4; 5th cycle o_b_ready=1, o_stall=1; next cycle writes x7=0x11, counter=0.
REQ-034 Conflict: A(addr=3, 0xA) and B(addr=3, 0xB) same cycle, counter=0 -> both ready; only x3=0xA written, no B write follows.
REQ-035 x0: B valid addr=0 data=0xFFFFFFFF alone -> o_b_ready=1; next cycle o_rd_wren=0.
REQ-036 Reset mid-op: counter=3, assert i_rst one cycle with both valid -> readies 0, wren=0, counter=0; after release A granted first.
REQ-037 Idle: no valids for 3 cycles -> o_rd_wren=0 throughout, o_rd_addr/data unchanged.
